// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - RAW interlock, branch redirect and data-memory wait sequencer for a 5-stage pipe
module hazard_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             mem_access,
  input  logic             dmem_ack,
  input  logic             mem_redirect,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  typedef enum logic [1:0] {RUN, RAW_STALL, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       TMO     = 8'(MEM_TIMEOUT);

  state_t     state, next_state;
  logic [1:0] stall_left, next_stall_left;
  logic [7:0] timer, next_timer;
  logic       hit_ex, hit_mem, hit_wb;
  logic [1:0] haz_len;
  logic       wait_cond, release_now, timeout_now, redirect_evt;

  assign hit_ex  = ex_reg_write && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign hit_mem = mem_reg_write && (mem_rd != 5'd0) &&
                   ((id_use_rs1 && id_rs1 == mem_rd) || (id_use_rs2 && id_rs2 == mem_rd));
  assign hit_wb  = wb_reg_write && (wb_rd != 5'd0) &&
                   ((id_use_rs1 && id_rs1 == wb_rd) || (id_use_rs2 && id_rs2 == wb_rd));

  // Youngest producer sets the length: the regfile is not write-through.
  assign haz_len = hit_ex ? 2'd3 : hit_mem ? 2'd2 : hit_wb ? 2'd1 : 2'd0;

  assign wait_cond   = mem_access && !dmem_ack;
  assign timeout_now = (state == MEM_WAIT) && !dmem_ack && (timer == TMO);
  assign release_now = (state == MEM_WAIT) && (dmem_ack || timer == TMO);

  always_comb begin
    pc_we           = 1'b1;
    if_id_we        = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_flush    = 1'b0;
    pipe_freeze     = 1'b0;
    next_state      = RUN;
    next_stall_left = 2'd0;
    next_timer      = timer;
    redirect_evt    = 1'b0;
    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (state == MEM_WAIT && !release_now) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      pipe_freeze = 1'b1;
      next_state  = MEM_WAIT;
      next_timer  = timer + 8'd1;
    end else if (state != MEM_WAIT && wait_cond) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      pipe_freeze = 1'b1;
      next_state  = MEM_WAIT;
      next_timer  = 8'd1;
    end else if (mem_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      redirect_evt = 1'b1;
    end else if (state == RAW_STALL) begin
      pc_we           = 1'b0;
      if_id_we        = 1'b0;
      id_ex_flush     = 1'b1;
      next_stall_left = stall_left - 2'd1;
      next_state      = (stall_left == 2'd1) ? RUN : RAW_STALL;
    end else if (haz_len != 2'd0) begin
      pc_we           = 1'b0;
      if_id_we        = 1'b0;
      id_ex_flush     = 1'b1;
      next_stall_left = haz_len - 2'd1;
      next_state      = (haz_len > 2'd1) ? RAW_STALL : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      stall_left <= 2'd0;
      timer      <= 8'd0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      mem_err    <= 1'b0;
    end else begin
      state      <= next_state;
      stall_left <= next_stall_left;
      timer      <= next_timer;
      if (!pc_we && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
      if (redirect_evt && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_ONE;
      if (timeout_now)
        mem_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed and randomized checks of hazard_sequencer against a cycle model
module tb_hazard_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_reg_write, mem_reg_write, wb_reg_write;
  logic       mem_access, dmem_ack, mem_redirect;

  logic        a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_pipe_freeze, a_mem_err;
  logic [3:0]  a_stall_cnt, a_flush_cnt;
  logic        b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze, b_mem_err;
  logic [31:0] b_stall_cnt, b_flush_cnt;

  // Instance a: narrow counters, long timeout. Instance b: wide counters, short timeout.
  hazard_sequencer #(.CNT_W(4), .MEM_TIMEOUT(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .mem_access(mem_access), .dmem_ack(dmem_ack),
    .mem_redirect(mem_redirect), .pc_we(a_pc_we), .if_id_we(a_if_id_we), .if_id_flush(a_if_id_flush),
    .id_ex_flush(a_id_ex_flush), .ex_mem_flush(a_ex_mem_flush), .pipe_freeze(a_pipe_freeze),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .mem_err(a_mem_err)
  );

  hazard_sequencer #(.CNT_W(32), .MEM_TIMEOUT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .mem_access(mem_access), .dmem_ack(dmem_ack),
    .mem_redirect(mem_redirect), .pc_we(b_pc_we), .if_id_we(b_if_id_we), .if_id_flush(b_if_id_flush),
    .id_ex_flush(b_id_ex_flush), .ex_mem_flush(b_ex_mem_flush), .pipe_freeze(b_pipe_freeze),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .mem_err(b_mem_err)
  );

  // Control vector order: pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush, pipe_freeze
  logic [5:0]  ctl [2];
  logic [31:0] scnt [2];
  logic [31:0] fcnt [2];
  logic        merr [2];
  assign ctl[0]  = {a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_flush, a_ex_mem_flush, a_pipe_freeze};
  assign ctl[1]  = {b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_flush, b_ex_mem_flush, b_pipe_freeze};
  assign scnt[0] = {28'd0, a_stall_cnt};
  assign scnt[1] = b_stall_cnt;
  assign fcnt[0] = {28'd0, a_flush_cnt};
  assign fcnt[1] = b_flush_cnt;
  assign merr[0] = a_mem_err;
  assign merr[1] = b_mem_err;

  localparam logic [5:0] C_RESET = 6'b001110;
  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_REDIR = 6'b111110;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_FRZ   = 6'b000001;

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per instance.
  int     m_waiting [2];
  int     m_wait_n  [2];
  int     m_extra   [2];
  int     m_err     [2];
  longint m_sc      [2];
  longint m_fc      [2];
  int     tmo       [2] = '{6, 3};
  longint cmax      [2] = '{15, 64'hFFFF_FFFF};

  function automatic bit producer_hits(input logic [4:0] rd, input logic we);
    return we && rd != 5'd0 && ((id_use_rs1 && id_rs1 == rd) || (id_use_rs2 && id_rs2 == rd));
  endfunction

  function automatic int hazard_len();
    int len = 0;
    if (producer_hits(wb_rd, wb_reg_write))   len = 1;
    if (producer_hits(mem_rd, mem_reg_write)) len = 2;
    if (producer_hits(ex_rd, ex_reg_write))   len = 3;
    return len;
  endfunction

  // Expected control for the current inputs; advances the model across the coming edge.
  task automatic model_step(input int m, output logic [5:0] e);
    int len;
    bit released;
    len = hazard_len();
    released = 0;
    if (!rst_n) begin
      e = C_RESET;
      m_waiting[m] = 0; m_wait_n[m] = 0; m_extra[m] = 0;
      m_err[m] = 0; m_sc[m] = 0; m_fc[m] = 0;
    end else begin
      if (m_waiting[m] != 0 && !dmem_ack && m_wait_n[m] < tmo[m]) begin
        e = C_FRZ;
        m_wait_n[m]++;
      end else begin
        if (m_waiting[m] != 0) begin
          released = 1;
          if (!dmem_ack) m_err[m] = 1;
          m_waiting[m] = 0;
        end
        if (!released && mem_access && !dmem_ack) begin
          e = C_FRZ;
          m_waiting[m] = 1; m_wait_n[m] = 1; m_extra[m] = 0;
        end else if (mem_redirect) begin
          e = C_REDIR;
          m_extra[m] = 0;
          if (m_fc[m] < cmax[m]) m_fc[m]++;
        end else if (m_extra[m] > 0) begin
          e = C_STALL;
          m_extra[m]--;
        end else if (len > 0) begin
          e = C_STALL;
          m_extra[m] = len - 1;
        end else begin
          e = C_RUN;
        end
      end
      if (!e[5] && m_sc[m] < cmax[m]) m_sc[m]++;
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_reg_write = 0; mem_rd = 0; mem_reg_write = 0;
    wb_rd = 0; wb_reg_write = 0; mem_access = 0; dmem_ack = 0; mem_redirect = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ctl[m] !== C_RESET) begin
        errors++; $display("FAIL reset_outputs dut%0d: got %b expected %b", m, ctl[m], C_RESET);
      end
    end
    cyc();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (scnt[m] !== 0 || fcnt[m] !== 0 || merr[m] !== 1'b0) begin
        errors++; $display("FAIL reset_state dut%0d: got stall=%0d flush=%0d err=%b expected 0 0 0",
                           m, scnt[m], fcnt[m], merr[m]);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ctl[0] !== C_RUN || ctl[1] !== C_RUN) begin
      errors++; $display("FAIL reset_release: got %b/%b expected %b", ctl[0], ctl[1], C_RUN);
    end
  endtask

  task automatic test_raw_ex();
    int bubbles = 0;
    do_reset();
    id_rs1 = 5; id_use_rs1 = 1; ex_rd = 5; ex_reg_write = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin ex_reg_write = 0; mem_rd = 5; mem_reg_write = 1; end
      if (k == 2) begin mem_reg_write = 0; wb_rd = 5; wb_reg_write = 1; end
      if (k == 3) wb_reg_write = 0;
      #1;
      checks++;
      if (a_pc_we !== (k >= 3)) begin
        errors++; $display("FAIL raw_ex_pc_we cycle %0d: got %b expected %b", k, a_pc_we, k >= 3);
      end
      if (a_id_ex_flush) bubbles++;
      cyc();
    end
    checks++;
    if (bubbles != 3) begin
      errors++; $display("FAIL raw_ex_bubbles: got %0d expected 3", bubbles);
    end
    checks++;
    if (scnt[0] !== 3 || scnt[1] !== 3) begin
      errors++; $display("FAIL raw_ex_stall_cnt: got %0d/%0d expected 3", scnt[0], scnt[1]);
    end
  endtask

  task automatic test_x0();
    do_reset();
    id_rs1 = 0; id_use_rs1 = 1; ex_rd = 0; ex_reg_write = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (a_pc_we !== 1'b1 || b_pc_we !== 1'b1) begin
        errors++; $display("FAIL x0_no_stall cycle %0d: got %b/%b expected 1", k, a_pc_we, b_pc_we);
      end
      cyc();
    end
    checks++;
    if (scnt[0] !== 0) begin
      errors++; $display("FAIL x0_stall_cnt: got %0d expected 0", scnt[0]);
    end
  endtask

  task automatic test_redirect_in_stall();
    do_reset();
    id_rs2 = 7; id_use_rs2 = 1; ex_rd = 7; ex_reg_write = 1;
    cyc();
    idle();
    mem_redirect = 1;
    #1;
    checks++;
    if (ctl[0] !== C_REDIR || ctl[1] !== C_REDIR) begin
      errors++; $display("FAIL redirect_outputs: got %b/%b expected %b", ctl[0], ctl[1], C_REDIR);
    end
    cyc();
    mem_redirect = 0;
    #1;
    checks++;
    if (ctl[0] !== C_RUN) begin
      errors++; $display("FAIL redirect_back_to_run: got %b expected %b", ctl[0], C_RUN);
    end
    checks++;
    if (fcnt[0] !== 1 || fcnt[1] !== 1 || scnt[0] !== 1) begin
      errors++; $display("FAIL redirect_counters: got flush=%0d/%0d stall=%0d expected 1/1 stall=1",
                         fcnt[0], fcnt[1], scnt[0]);
    end
  endtask

  task automatic test_mem_wait();
    int frz = 0;
    do_reset();
    mem_access = 1; dmem_ack = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (ctl[0] === C_FRZ) frz++;
      cyc();
    end
    checks++;
    if (frz != 4) begin
      errors++; $display("FAIL mem_wait_freeze_cycles: got %0d expected 4", frz);
    end
    dmem_ack = 1;
    #1;
    checks++;
    if (ctl[0] !== C_RUN) begin
      errors++; $display("FAIL mem_wait_release: got %b expected %b", ctl[0], C_RUN);
    end
    cyc();
    idle();
    checks++;
    if (a_mem_err !== 1'b0 || scnt[0] !== 4) begin
      errors++; $display("FAIL mem_wait_after: got err=%b stall=%0d expected err=0 stall=4", a_mem_err, scnt[0]);
    end
    checks++;
    if (b_mem_err !== 1'b1) begin
      errors++; $display("FAIL mem_wait_short_timeout_err: got %b expected 1", b_mem_err);
    end
  endtask

  task automatic test_timeout();
    logic [5:0] exp;
    do_reset();
    mem_access = 1; dmem_ack = 0;
    for (int k = 0; k < 4; k++) begin
      exp = (k < 3) ? C_FRZ : C_RUN;
      #1;
      checks++;
      if (ctl[1] !== exp) begin
        errors++; $display("FAIL timeout_ctl cycle %0d: got %b expected %b", k, ctl[1], exp);
      end
      cyc();
    end
    idle();
    for (int k = 0; k < 3; k++) cyc();
    checks++;
    if (b_mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b expected 1", b_mem_err);
    end
    do_reset();
    checks++;
    if (b_mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_cleared_by_reset: got %b expected 0", b_mem_err);
    end
  endtask

  task automatic test_saturation();
    int zeros = 0;
    do_reset();
    id_rs1 = 9; id_use_rs1 = 1; ex_rd = 9; ex_reg_write = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (a_pc_we === 1'b0) zeros++;
      cyc();
    end
    checks++;
    if (zeros != 20) begin
      errors++; $display("FAIL sat_continuous_stall: got %0d stall cycles expected 20", zeros);
    end
    checks++;
    if (scnt[0] !== 15 || scnt[1] !== 20) begin
      errors++; $display("FAIL sat_stall_cnt: got %0d/%0d expected 15/20", scnt[0], scnt[1]);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    idle();
    #1;
    checks++;
    if (scnt[0] !== 0 || scnt[1] !== 0 || fcnt[0] !== 0 || ctl[0] !== C_RUN) begin
      errors++; $display("FAIL sat_mid_reset: got stall=%0d/%0d flush=%0d ctl=%b expected 0/0 0 %b",
                         scnt[0], scnt[1], fcnt[0], ctl[0], C_RUN);
    end
  endtask

  task automatic test_random();
    logic [5:0] exp;
    for (int i = 0; i < 3000; i++) begin
      rst_n         = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      ex_rd         = 5'($urandom_range(0, 3));
      mem_rd        = 5'($urandom_range(0, 3));
      wb_rd         = 5'($urandom_range(0, 3));
      ex_reg_write  = ($urandom_range(0, 9) < 3);
      mem_reg_write = ($urandom_range(0, 9) < 3);
      wb_reg_write  = ($urandom_range(0, 9) < 3);
      mem_access    = ($urandom_range(0, 99) < 15);
      dmem_ack      = ($urandom_range(0, 9) < 4);
      mem_redirect  = !mem_access && ($urandom_range(0, 99) < 8);
      #1;
      for (int m = 0; m < 2; m++) begin
        model_step(m, exp);
        checks++;
        if (ctl[m] !== exp) begin
          errors++; $display("FAIL rand_ctl dut%0d cycle %0d: got %b expected %b", m, i, ctl[m], exp);
        end
      end
      cyc();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (scnt[m] !== 32'(m_sc[m]) || fcnt[m] !== 32'(m_fc[m]) || merr[m] !== 1'(m_err[m])) begin
          errors++; $display("FAIL rand_state dut%0d cycle %0d: got stall=%0d flush=%0d err=%b expected %0d %0d %0d",
                             m, i, scnt[m], fcnt[m], merr[m], m_sc[m], m_fc[m], m_err[m]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_raw_ex();
    test_x0();
    test_redirect_in_stall();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
